// File: rtl/w_update_tx_if.sv
// Weight-update port bundle: adaptation-side weight input, refresh control and the FIR update strobe.
interface w_update_tx_if #(
  parameter int N    = 1008,
  parameter int WQ_W = 16
);
  localparam int IDX_W = $clog2(N);

  logic                    w_valid;
  logic                    w_ready;
  logic [IDX_W-1:0]        w_idx;
  logic signed [WQ_W-1:0]  w_data;
  logic                    refresh_req;
  logic                    busy;
  logic                    valid_update_out;
  logic [IDX_W-1:0]        update_idx;
  logic [1:0]              update_data;

  modport slave (
    input  w_valid, w_idx, w_data, refresh_req,
    output w_ready, busy, valid_update_out, update_idx, update_data
  );

  modport master (
    output w_valid, w_idx, w_data, refresh_req,
    input  w_ready, busy, valid_update_out, update_idx, update_data
  );
endinterface

// File: rtl/w_update_tx.sv
// Weight-update transmitter: quantizes weights to {mag, sign}, keeps a shadow of sent codes and replays it on refresh.
// Optional W_UPD_SKIP_EN suppresses updates whose code already matches the shadow entry.
module w_update_tx #(
  parameter int N      = 1008,
  parameter int WQ_W   = 16,
  parameter int THRESH = 16
) (
  input  logic         clock,
  input  logic         reset,
  w_update_tx_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [IDX_W-1:0]       r_cnt;
  logic                   r_pending;
  logic                   r_ready;
  logic                   r_valid;
  logic [IDX_W-1:0]       r_idx;
  logic [1:0]             r_data;
  logic [1:0]             r_shadow [N];

  logic                   w_accept;
  logic                   w_in_range;
  logic                   w_emit;
  logic                   w_pending_next;
  logic                   w_ready_next;
  logic [IDX_W-1:0]       w_safe_idx;
  logic signed [WQ_W:0]   w_ext;
  logic signed [WQ_W:0]   w_thresh;
  logic                   w_mag;
  logic                   w_sign;
  logic [1:0]             w_code;
  logic [1:0]             w_shadow_cur;
  logic [1:0]             w_sweep_code;

  assign w_accept   = bus.w_valid && r_ready;
  assign w_in_range = {1'b0, bus.w_idx} < N_EXT;
  assign w_safe_idx = w_in_range ? bus.w_idx : '0;

  // One extra bit so negating the threshold and the most-negative weight cannot overflow.
  assign w_ext    = {bus.w_data[WQ_W-1], bus.w_data};
  assign w_thresh = (WQ_W+1)'(THRESH);
  assign w_sign   = bus.w_data[WQ_W-1];
  assign w_mag    = (w_ext >= w_thresh) || (w_ext <= -w_thresh);
  assign w_code   = {w_mag, w_sign};

  assign w_shadow_cur = r_shadow[w_safe_idx];
  assign w_sweep_code = r_shadow[r_cnt];

`ifdef W_UPD_SKIP_EN
  assign w_emit = w_accept && w_in_range && (w_code != w_shadow_cur);
`else
  assign w_emit = w_accept && w_in_range;
  logic w_unused;
  assign w_unused = ^w_shadow_cur;
`endif

  // A refresh that collides with an emitted weight waits one cycle so the weight goes out first.
  assign w_pending_next = (r_state == S_IDLE) && !r_pending && bus.refresh_req && w_emit;
  assign w_ready_next   = (w_next == S_IDLE) && !w_pending_next;
  assign bus.w_ready    = r_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next               = r_state;
    bus.busy             = 1'b0;
    bus.valid_update_out = r_valid;
    bus.update_idx       = r_idx;
    bus.update_data      = r_data;
    case (r_state)
      S_IDLE: begin
        if (r_pending || (bus.refresh_req && !w_emit)) begin
          w_next = S_SWEEP;
        end
      end
      S_SWEEP: begin
        bus.busy             = 1'b1;
        bus.valid_update_out = 1'b1;
        bus.update_idx       = r_cnt;
        bus.update_data      = w_sweep_code;
        if (r_cnt == LAST_IDX) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_data    <= 2'b00;
    end else begin
      r_pending <= w_pending_next;
      r_ready   <= w_ready_next;
      r_valid   <= w_emit;
      if (r_state == S_SWEEP) begin
        r_cnt  <= r_cnt + IDX_W'(1);
        r_idx  <= r_cnt;
        r_data <= w_sweep_code;
      end else begin
        r_cnt <= '0;
        if (w_emit) begin
          r_idx  <= bus.w_idx;
          r_data <= w_code;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= 2'b00;
      end
    end else if (w_emit) begin
      r_shadow[w_safe_idx] <= w_code;
    end
  end
endmodule

// File: tb/tb_w_update_tx.sv
// Directed bench for w_update_tx: quantizer edges, skip behaviour, out-of-range index, refresh sweeps and reset mid-sweep.
module tb_w_update_tx;
  localparam int N    = 1008;
  localparam int WQ_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   obsCount;
  int   expCount;

  logic [1:0] mdl [N];
  logic [9:0] lastIdx;
  logic [1:0] lastData;

  w_update_tx_if #(.N(N), .WQ_W(WQ_W)) bus ();

  w_update_tx #(.N(N), .WQ_W(WQ_W), .THRESH(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [14:0] vec(input logic v, input logic b, input logic r,
                                      input logic [9:0] i, input logic [1:0] d);
    return {v, b, r, i, d};
  endfunction

  task automatic applyStimulus(input logic v, input logic [9:0] idx,
                               input logic signed [15:0] d, input logic rf);
    bus.w_valid     = v;
    bus.w_idx       = idx;
    bus.w_data      = d;
    bus.refresh_req = rf;
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {bus.valid_update_out, bus.busy, bus.w_ready, bus.update_idx, bus.update_data};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed {v,busy,rdy,idx,data}=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send one in-range weight and check the update that appears one cycle later.
  task automatic sendWeight(input string tag, input logic [9:0] idx,
                            input logic signed [15:0] d, input logic [1:0] code);
    logic doEmit;
    applyStimulus(1'b1, idx, d, 1'b0);
    @(negedge clock);
    doEmit = 1'b1;
`ifdef W_UPD_SKIP_EN
    doEmit = (mdl[idx] != code);
`endif
    if (doEmit) begin
      lastIdx  = idx;
      lastData = code;
      mdl[idx] = code;
    end
    checkOutput(tag, vec(doEmit, 1'b0, 1'b1, lastIdx, lastData));
  endtask

  task automatic runSweep(input string tag, input int lastI, input bit poke);
    for (int i = 0; i <= lastI; i++) begin
      checkOutput($sformatf("%s_idx%0d", tag, i), vec(1'b1, 1'b1, 1'b0, 10'(i), mdl[i]));
      if (i == 0) bus.refresh_req = 1'b0;
      if (poke && i == 10) applyStimulus(1'b1, 10'd20, 16'sd20, 1'b0);
      if (poke && i == 500) bus.refresh_req = 1'b1;
      if (poke && i == 501) bus.refresh_req = 1'b0;
      if (i == N - 1) applyStimulus(1'b0, 10'd0, 16'sd0, 1'b0);
      if (i < lastI) @(negedge clock);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 10'd0, 16'sd0, 1'b0);
    for (int i = 0; i < N; i++) mdl[i] = 2'b00;
    lastIdx  = 10'd0;
    lastData = 2'b00;

    repeat (3) @(negedge clock);
    checkOutput("reset_state", vec(1'b0, 1'b0, 1'b0, 10'd0, 2'b00));
    reset = 1'b1;
    @(negedge clock);
    checkOutput("ready_after_release", vec(1'b0, 1'b0, 1'b1, 10'd0, 2'b00));

    sendWeight("basic_idx5", 10'd5, 16'sd20, 2'b10);
    sendWeight("quant_m3", 10'd10, -16'sd3, 2'b01);
    sendWeight("quant_m16", 10'd11, -16'sd16, 2'b11);
    sendWeight("quant_p15", 10'd12, 16'sd15, 2'b00);
    sendWeight("quant_zero", 10'd13, 16'sd0, 2'b00);
    sendWeight("quant_minneg", 10'd14, 16'sh8000, 2'b11);
    sendWeight("quant_p16", 10'd15, 16'sd16, 2'b10);
    applyStimulus(1'b0, 10'd0, 16'sd0, 1'b0);
    @(negedge clock);
    checkOutput("idle_hold", vec(1'b0, 1'b0, 1'b1, lastIdx, lastData));

    obsCount = 0;
    sendWeight("skip_first", 10'd3, 16'sd20, 2'b10);
    obsCount += int'(bus.valid_update_out);
    sendWeight("skip_second", 10'd3, 16'sd20, 2'b10);
    obsCount += int'(bus.valid_update_out);
    applyStimulus(1'b0, 10'd0, 16'sd0, 1'b0);
    @(negedge clock);
    obsCount += int'(bus.valid_update_out);
`ifdef W_UPD_SKIP_EN
    expCount = 1;
`else
    expCount = 2;
`endif
    checks++;
    assert (obsCount === expCount) else begin
      errors++;
      $error("[TB] FAIL skip_count: observed=%0d expected=%0d", obsCount, expCount);
    end

    applyStimulus(1'b1, 10'd1008, 16'sd20, 1'b0);
    @(negedge clock);
    checkOutput("oor_no_output", vec(1'b0, 1'b0, 1'b1, lastIdx, lastData));
    applyStimulus(1'b0, 10'd0, 16'sd0, 1'b0);
    @(negedge clock);
    checkOutput("oor_quiet", vec(1'b0, 1'b0, 1'b1, lastIdx, lastData));

    sendWeight("idx7_neg", 10'd7, -16'sd16, 2'b11);
    applyStimulus(1'b0, 10'd0, 16'sd0, 1'b1);
    @(negedge clock);
    runSweep("sweep1", N - 1, 1'b1);
    lastIdx  = 10'(N - 1);
    lastData = mdl[N-1];
    @(negedge clock);
    checkOutput("sweep1_done", vec(1'b0, 1'b0, 1'b1, lastIdx, lastData));
    @(negedge clock);
    checkOutput("sweep1_no_requeue", vec(1'b0, 1'b0, 1'b1, lastIdx, lastData));

    applyStimulus(1'b1, 10'd7, 16'sd16, 1'b1);
    @(negedge clock);
    mdl[7]   = 2'b10;
    lastIdx  = 10'd7;
    lastData = 2'b10;
    checkOutput("weight_before_sweep", vec(1'b1, 1'b0, 1'b0, 10'd7, 2'b10));
    applyStimulus(1'b0, 10'd0, 16'sd0, 1'b0);
    @(negedge clock);
    runSweep("sweep2", 100, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_mid_sweep", vec(1'b0, 1'b0, 1'b0, 10'd0, 2'b00));
    @(negedge clock);
    checkOutput("reset_held", vec(1'b0, 1'b0, 1'b0, 10'd0, 2'b00));
    reset = 1'b1;
    for (int i = 0; i < N; i++) mdl[i] = 2'b00;
    @(negedge clock);
    checkOutput("ready_after_reset2", vec(1'b0, 1'b0, 1'b1, 10'd0, 2'b00));

    applyStimulus(1'b0, 10'd0, 16'sd0, 1'b1);
    @(negedge clock);
    runSweep("sweep3", N - 1, 1'b0);
    @(negedge clock);
    checkOutput("sweep3_done", vec(1'b0, 1'b0, 1'b1, 10'(N - 1), 2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
